// File: rtl/score_display.sv
// Binary-to-seven-segment display driver: sequential double-dabble conversion,
// leading-zero blanking, overflow dashes. Optional blinking via SCORE_DISPLAY_BLINK_EN.
module score_display #(
    parameter int DIGITS    = 4,
    parameter int BIN_W     = 14,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [BIN_W-1:0]      value,
    input  logic                  blank_lz,
`ifdef SCORE_DISPLAY_BLINK_EN
    input  logic                  blink,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [7*DIGITS-1:0]   seg_o
);

    typedef enum logic [1:0] {IDLE, CONV, LATCH} state_t;

    localparam int          CNT_W     = $clog2(BIN_W + 1);
    localparam int          BCD_W     = 4 * DIGITS;
    localparam logic [63:0] MAX_VAL   = 64'(10 ** DIGITS) - 64'd1;
    localparam logic [6:0]  SEG_BLANK = 7'b1111111;
    localparam logic [6:0]  SEG_DASH  = 7'b0111111;

    if (DIGITS < 1 || DIGITS > 8 || BIN_W < 1 || BLINK_DIV < 1) begin : g_param_check
        $error("score_display: parameter out of range");
    end

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = SEG_BLANK;
        endcase
    endfunction

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BIN_W-1:0]      bin_q, bin_d;
    logic [BCD_W-1:0]      bcd_q, bcd_d, bcd_adj;
    logic                  blank_q, blank_d;
    logic                  ovf_pend_q, ovf_pend_d;
    logic                  ovf_q, ovf_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic [7*DIGITS-1:0]   img_q, img_d, img_calc;
    logic                  lz;
    logic [3:0]            nib;

    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5)
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end
    end

    // Scan from the top digit down; digit 0 is always shown so zero reads "0".
    always_comb begin
        img_calc = '1;
        lz       = blank_q;
        nib      = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            nib = bcd_q[4*k +: 4];
            if (ovf_pend_q)
                img_calc[7*k +: 7] = SEG_DASH;
            else if (lz && nib == 4'd0 && k != 0)
                img_calc[7*k +: 7] = SEG_BLANK;
            else begin
                lz                 = 1'b0;
                img_calc[7*k +: 7] = seg_decode(nib);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        blank_d    = blank_q;
        ovf_pend_d = ovf_pend_q;
        ovf_d      = ovf_q;
        img_d      = img_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    bin_d      = value;
                    blank_d    = blank_lz;
                    ovf_pend_d = 64'(value) > MAX_VAL;
                    bcd_d      = '0;
                    cnt_d      = CNT_W'(BIN_W);
                    state_d    = CONV;
                end
            end
            CONV: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                cnt_d          = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1))
                    state_d = LATCH;
            end
            LATCH: begin
                img_d   = img_calc;
                ovf_d   = ovf_pend_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            img_q   <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            img_q   <= img_d;
        end
    end

    // Conversion datapath carries no reset; it is always reloaded on an accepted load.
    always_ff @(posedge clk) begin
        bin_q      <= bin_d;
        bcd_q      <= bcd_d;
        blank_q    <= blank_d;
        ovf_pend_q <= ovf_pend_d;
    end

`ifdef SCORE_DISPLAY_BLINK_EN
    localparam int BD_W = $clog2(BLINK_DIV + 1);

    logic [BD_W-1:0]     bcnt_q;
    logic                phase_q;
    logic [7*DIGITS-1:0] seg_q;

    // Output register mirrors img_d so a fresh image still lands with done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt_q  <= '0;
            phase_q <= 1'b0;
            seg_q   <= '1;
        end else begin
            if (bcnt_q == BD_W'(BLINK_DIV - 1)) begin
                bcnt_q  <= '0;
                phase_q <= ~phase_q;
            end else begin
                bcnt_q <= bcnt_q + BD_W'(1);
            end
            seg_q <= (blink && phase_q) ? '1 : img_d;
        end
    end

    assign seg_o = seg_q;
`else
    assign seg_o = img_q;
`endif

    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = ovf_q;

endmodule
